// File: rtl/vga_display_arbiter.sv
// Write-port arbiter for the VGA character RAM: round-robin between two requesters plus a
// full-buffer clear sequencer. Define VGA_ARB_STATS_EN to add per-requester grant counters.
module vga_display_arbiter #(
  parameter int DEPTH = 2400,
  parameter int AW    = 12,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  input  logic          clear_start,
  input  logic [DW-1:0] clear_char,
  output logic          clear_busy,
  output logic          clear_done,
  output logic          oob_err,
`ifdef VGA_ARB_STATS_EN
  output logic [31:0]   grant0_cnt,
  output logic [31:0]   grant1_cnt,
`endif
  output logic          display_wen,
  output logic [AW-1:0] display_w_addr,
  output logic [DW-1:0] display_w_data
);

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic {ARB, CLEAR} state_t;

  state_t        state, state_nxt;
  logic          last_grant;   // 1: requester 1 was granted last, so requester 0 wins a tie
  logic [AW-1:0] cnt;
  logic [DW-1:0] fill;
  logic          grant0, grant1, start_clr;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          in_range;

  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    start_clr = 1'b0;
    if (state == CLEAR) begin
      if (cnt == LAST) state_nxt = ARB;
    end else if (clear_start) begin
      start_clr = 1'b1;
      state_nxt = CLEAR;
    end else if (req0_valid && req1_valid) begin
      grant0 = last_grant;
      grant1 = !last_grant;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  // Ready is combinational, so gate it to keep every output low while reset is held.
  assign req0_ready = grant0 & ~rst;
  assign req1_ready = grant1 & ~rst;

  assign sel_addr = grant0 ? req0_addr : req1_addr;
  assign sel_data = grant0 ? req0_data : req1_data;
  assign in_range = {1'b0, sel_addr} < DEPTH_W;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ARB;
      last_grant     <= 1'b1;
      cnt            <= '0;
      fill           <= '0;
      display_wen    <= 1'b0;
      display_w_addr <= '0;
      display_w_data <= '0;
      clear_busy     <= 1'b0;
      clear_done     <= 1'b0;
      oob_err        <= 1'b0;
    end else begin
      state       <= state_nxt;
      display_wen <= 1'b0;
      clear_done  <= 1'b0;
      clear_busy  <= (state == CLEAR) | start_clr;
      if (state == CLEAR) begin
        display_wen    <= 1'b1;
        display_w_addr <= cnt;
        display_w_data <= fill;
        if (cnt == LAST) clear_done <= 1'b1;
        else             cnt        <= cnt + AW'(1);
      end else if (start_clr) begin
        fill <= clear_char;
        cnt  <= '0;
      end else if (grant0 || grant1) begin
        last_grant <= grant1;
        // Out-of-range writes are acked to keep the requester moving but never reach the RAM.
        if (in_range) begin
          display_wen    <= 1'b1;
          display_w_addr <= sel_addr;
          display_w_data <= sel_data;
        end else begin
          oob_err <= 1'b1;
        end
      end
    end
  end

`ifdef VGA_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant0_cnt <= '0;
      grant1_cnt <= '0;
    end else begin
      if (grant0) grant0_cnt <= grant0_cnt + 32'd1;
      if (grant1) grant1_cnt <= grant1_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_display_arbiter.sv
// Randomized bench for vga_display_arbiter against a queue-based model of the write stream.
module tb_vga_display_arbiter;
  localparam int DEPTH = 2400;
  localparam int AW    = 12;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          clear_start = 1'b0;
  logic [DW-1:0] clear_char = '0;
  logic          req0_ready, req1_ready, clear_busy, clear_done, oob_err;
  logic          display_wen;
  logic [AW-1:0] display_w_addr;
  logic [DW-1:0] display_w_data;
`ifdef VGA_ARB_STATS_EN
  logic [31:0]   grant0_cnt, grant1_cnt;
`endif

  always #5 clk = ~clk;

  vga_display_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .clear_start(clear_start), .clear_char(clear_char),
    .clear_busy(clear_busy), .clear_done(clear_done), .oob_err(oob_err),
`ifdef VGA_ARB_STATS_EN
    .grant0_cnt(grant0_cnt), .grant1_cnt(grant1_cnt),
`endif
    .display_wen(display_wen), .display_w_addr(display_w_addr), .display_w_data(display_w_data)
  );

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a clear is a queue of DEPTH pending writes that drains one per cycle.
  int            clr_q[$];
  int            rr_winner;        // requester that wins the next tie
  bit            e0, e1;
  bit            m_wen, m_busy, m_done, m_oob;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, m_fill;
  int unsigned   m_g0, m_g1;
  int            done_seen;

  task automatic model_reset();
    clr_q.delete();
    rr_winner = 0;
    e0 = 0; e1 = 0;
    m_wen = 0; m_busy = 0; m_done = 0; m_oob = 0;
    m_addr = '0; m_data = '0; m_fill = '0;
    m_g0 = 0; m_g1 = 0;
  endtask

  task automatic model_ready();
    e0 = 0; e1 = 0;
    if (rst || clr_q.size() != 0 || clear_start) return;
    if (req0_valid && req1_valid) begin
      if (rr_winner == 0) e0 = 1; else e1 = 1;
    end else begin
      e0 = req0_valid;
      e1 = req1_valid;
    end
  endtask

  task automatic model_edge();
    logic [AW-1:0] a;
    m_wen  = 0;
    m_done = 0;
    if (clr_q.size() != 0) begin
      m_wen  = 1;
      m_addr = AW'(clr_q.pop_front());
      m_data = m_fill;
      m_busy = 1;
      m_done = (clr_q.size() == 0);
    end else if (clear_start) begin
      for (int i = 0; i < DEPTH; i++) clr_q.push_back(i);
      m_fill = clear_char;
      m_busy = 1;
    end else begin
      m_busy = 0;
      if (e0 || e1) begin
        a = e0 ? req0_addr : req1_addr;
        rr_winner = e0 ? 1 : 0;
        if (e0) m_g0++; else m_g1++;
        if (int'(a) < DEPTH) begin
          m_wen  = 1;
          m_addr = a;
          m_data = e0 ? req0_data : req1_data;
        end else begin
          m_oob = 1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("wen",   32'(display_wen),    32'(m_wen));
    chk("addr",  32'(display_w_addr), 32'(m_addr));
    chk("data",  32'(display_w_data), 32'(m_data));
    chk("busy",  32'(clear_busy),     32'(m_busy));
    chk("done",  32'(clear_done),     32'(m_done));
    chk("oob",   32'(oob_err),        32'(m_oob));
`ifdef VGA_ARB_STATS_EN
    chk("g0cnt", grant0_cnt, m_g0);
    chk("g1cnt", grant1_cnt, m_g1);
`endif
    if (clear_done === 1'b1) done_seen++;
  endtask

  // One clock: check readies mid-cycle, advance model at the edge, check outputs at negedge.
  task automatic cyc();
    #1;
    model_ready();
    chk("rdy0",   32'(req0_ready), 32'(e0));
    chk("rdy1",   32'(req1_ready), 32'(e1));
    chk("onehot", 32'(req0_ready & req1_ready), 32'd0);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    if (e0) req0_valid = 1'b0;
    if (e1) req1_valid = 1'b0;
    clear_start = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    done_seen = 0;
    req0_valid = 1'b1;
    #2;
    chk("rst_rdy0", 32'(req0_ready), 32'd0);
    check_outputs();
    req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // single req0 write, then idle cycle (addr/data hold)
    req0_valid = 1'b1; req0_addr = AW'(5); req0_data = 8'h41;
    cyc();
    cyc();

    // both requesters continuously valid: round-robin
    for (int k = 0; k < 4; k++) begin
      if (!req0_valid) begin req0_valid = 1'b1; req0_addr = AW'(100 + k); req0_data = DW'(8'h50 + k); end
      if (!req1_valid) begin req1_valid = 1'b1; req1_addr = AW'(200 + k); req1_data = DW'(8'h60 + k); end
      cyc();
    end
    repeat (3) cyc();

    // clear while req1 waits, with a second clear_start mid-clear
    req1_valid = 1'b1; req1_addr = AW'(7); req1_data = 8'h33;
    clear_start = 1'b1; clear_char = 8'h20;
    cyc();
    done_seen = 0;
    for (int k = 0; k < DEPTH + 3; k++) begin
      if (k == 12) clear_start = 1'b1;
      cyc();
    end
    chk("done_once", 32'(done_seen), 32'd1);

    // out-of-range request
    req0_valid = 1'b1; req0_addr = AW'(DEPTH); req0_data = 8'h55;
    cyc();
    repeat (3) cyc();

    // async reset in the middle of a clear
    clear_start = 1'b1; clear_char = 8'h2E;
    cyc();
    for (int k = 0; k < DEPTH && !(m_wen && m_addr == AW'(1000)); k++) cyc();
    chk("reached1000", 32'(m_addr), 32'd1000);
    rst = 1'b1;
    req0_valid = 1'b1; req0_addr = AW'(3);
    #1;
    model_reset();
    check_outputs();
    chk("rst_rdy0b", 32'(req0_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b0;
    clear_start = 1'b1; clear_char = 8'h2A;
    cyc();
    done_seen = 0;
    repeat (DEPTH + 2) cyc();
    chk("done_once2", 32'(done_seen), 32'd1);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if (!req0_valid && $urandom_range(0, 2) != 0) begin
        req0_valid = 1'b1;
        req0_addr  = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(DEPTH, 4095))
                                                  : AW'($urandom_range(0, DEPTH - 1));
        req0_data  = DW'($urandom());
      end
      if (!req1_valid && $urandom_range(0, 2) != 0) begin
        req1_valid = 1'b1;
        req1_addr  = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(DEPTH, 4095))
                                                  : AW'($urandom_range(0, DEPTH - 1));
        req1_data  = DW'($urandom());
      end
      if ($urandom_range(0, 799) == 0) begin
        clear_start = 1'b1;
        clear_char  = DW'($urandom());
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
